// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a first-word-fall-through receive FIFO.
// Decodes frames of DATA_BITS data bits (LSB first), optional parity and
// STOP_BITS stop bits at a runtime bit period, flags framing/parity errors
// and FIFO overrun, and buffers good words.
// Ports:
//   clk, resetn      system clock, asynchronous active-low reset
//   cfg_div          clk cycles per bit (values below 4 behave as 4)
//   rx               serial input, idle high, asynchronous to clk
//   rd_en            pop the FIFO head
//   rd_data          FIFO head word (valid while rd_valid)
//   rd_valid         FIFO not empty
//   level            FIFO occupancy 0..FIFO_DEPTH
//   frame_err        sticky: a stop bit was sampled low
//   parity_err       sticky: parity mismatch
//   overrun          sticky: a good word arrived while the FIFO was full
//   err_clr          clears all sticky flags (wins over a same-cycle event)
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_WAIT_HI = 3'd5
  } state_t;

  // Expected parity bit for a data word (even: XOR of data, odd: its inverse).
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    if (PARITY == 2) begin
      parity_bit = ^d;
    end else begin
      parity_bit = ~^d;
    end
  endfunction

  state_t                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   bad_q, bad_d;

  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   overrun_q, overrun_d;

  logic                   rxs_s;
  logic [DIV_W-1:0]       div_eff_s;
  logic                   expire_s, last_bit_s, last_stop_s;
  logic                   push_req_s, perr_ev_s, ferr_ev_s, ovr_ev_s;
  logic                   full_s, push_s, pop_s;

  assign rxs_s       = sync_q[1];
  assign div_eff_s   = (cfg_div < DIV_W'(3'd4)) ? DIV_W'(3'd4) : cfg_div;
  assign expire_s    = (cnt_q == DIV_W'(1'b1));
  assign last_bit_s  = (bit_cnt_q == BW'(DATA_BITS - 1));
  assign last_stop_s = (stop_cnt_q == 1'(STOP_BITS - 1));

  // Two-flop synchroniser input shift.
  always_comb begin
    sync_d = {sync_q[0], rx};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!rxs_s) state_d = S_START;
        else        state_d = S_IDLE;
      end
      S_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (expire_s) state_d = rxs_s ? S_IDLE : S_DATA;
        else          state_d = S_START;
      end
      S_DATA: begin
        if (expire_s && last_bit_s) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        else                        state_d = S_DATA;
      end
      S_PARITY: begin
        if (expire_s) state_d = S_STOP;
        else          state_d = S_PARITY;
      end
      S_STOP: begin
        // Returning to IDLE at mid stop bit lets back-to-back frames through;
        // a low last stop bit waits for the line to recover first.
        if (expire_s && last_stop_s) state_d = rxs_s ? S_IDLE : S_WAIT_HI;
        else                         state_d = S_STOP;
      end
      S_WAIT_HI: begin
        if (rxs_s) state_d = S_IDLE;
        else       state_d = S_WAIT_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output logic: bit counter, shifter, error events and push request.
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    data_d     = data_q;
    bad_d      = bad_q;
    push_req_s = 1'b0;
    perr_ev_s  = 1'b0;
    ferr_ev_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_s) begin
          // Bit period is frozen for the whole frame.
          div_d      = div_eff_s;
          cnt_d      = div_eff_s >> 1;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          bad_d      = 1'b0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_START: begin
        if (expire_s) cnt_d = div_q;
        else          cnt_d = cnt_q - DIV_W'(1'b1);
      end
      S_DATA: begin
        if (expire_s) begin
          cnt_d     = div_q;
          data_d    = {rxs_s, data_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1'b1);
        end else begin
          cnt_d = cnt_q - DIV_W'(1'b1);
        end
      end
      S_PARITY: begin
        if (expire_s) begin
          cnt_d = div_q;
          if (rxs_s != parity_bit(data_q)) begin
            bad_d     = 1'b1;
            perr_ev_s = 1'b1;
          end else begin
            bad_d = bad_q;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1'b1);
        end
      end
      S_STOP: begin
        if (expire_s) begin
          cnt_d      = div_q;
          stop_cnt_d = stop_cnt_q + 1'b1;
          if (!rxs_s) begin
            bad_d     = 1'b1;
            ferr_ev_s = 1'b1;
          end else begin
            bad_d = bad_q;
          end
          if (last_stop_s) push_req_s = !bad_q && rxs_s;
          else             push_req_s = 1'b0;
        end else begin
          cnt_d = cnt_q - DIV_W'(1'b1);
        end
      end
      S_WAIT_HI: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Synchroniser and receive datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      bad_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      data_q     <= data_d;
      bad_q      <= bad_d;
    end
  end

  // FIFO control, storage update and sticky flags.
  always_comb begin
    full_s   = (level_q == LW'(FIFO_DEPTH));
    pop_s    = rd_en && (level_q != '0);
    // When full, a same-cycle pop frees the slot being written.
    push_s   = push_req_s && (!full_s || pop_s);
    ovr_ev_s = push_req_s && full_s && !pop_s;
    mem_d    = mem_q;
    if (push_s) mem_d[wptr_q] = data_q;
    else        mem_d[wptr_q] = mem_q[wptr_q];
    wptr_d = push_s ? (wptr_q + PW'(1'b1)) : wptr_q;
    rptr_d = pop_s  ? (rptr_q + PW'(1'b1)) : rptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1'b1);
      2'b01:   level_d = level_q - LW'(1'b1);
      default: level_d = level_q;
    endcase
    rd_valid_d   = (level_d != '0);
    frame_err_d  = err_clr ? 1'b0 : (frame_err_q  | ferr_ev_s);
    parity_err_d = err_clr ? 1'b0 : (parity_err_q | perr_ev_s);
    overrun_d    = err_clr ? 1'b0 : (overrun_q    | ovr_ev_s);
  end

  // FIFO and flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      rd_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      level_q      <= level_d;
      rd_valid_q   <= rd_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rd_data    = mem_q[rptr_q];
  assign rd_valid   = rd_valid_q;
  assign level      = level_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 depth-8 instance and an 8E1 depth-4 instance.
module tb_uart_rx_fifo;

  logic        clk, resetn, err_clr;
  logic [15:0] cfg_div_n, cfg_div_e;
  logic        rx_n, rx_e, rd_en_n, rd_en_e;
  logic [7:0]  rd_data_n, rd_data_e;
  logic        rd_valid_n, rd_valid_e;
  logic [3:0]  level_n;
  logic [2:0]  level_e;
  logic        ferr_n, perr_n, ovr_n, ferr_e, perr_e, ovr_e;

  int checks = 0;
  int failures = 0;
  int lat;
  logic [7:0] q_n[$];
  logic [7:0] q_e[$];

  typedef struct {
    logic [7:0] data;
    logic       flip;
    logic       stop_v;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_push;
  } vec_t;
  vec_t tbl[7];
  logic [7:0] words[5];

  uart_rx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8), .DIV_W(16)) dut_n (
    .clk(clk), .resetn(resetn), .cfg_div(cfg_div_n), .rx(rx_n), .rd_en(rd_en_n),
    .rd_data(rd_data_n), .rd_valid(rd_valid_n), .level(level_n), .frame_err(ferr_n),
    .parity_err(perr_n), .overrun(ovr_n), .err_clr(err_clr));

  uart_rx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) dut_e (
    .clk(clk), .resetn(resetn), .cfg_div(cfg_div_e), .rx(rx_e), .rd_en(rd_en_e),
    .rd_data(rd_data_e), .rd_valid(rd_valid_e), .level(level_e), .frame_err(ferr_e),
    .parity_err(perr_e), .overrun(ovr_e), .err_clr(err_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic epar(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_e = v;
    else     rx_n = v;
  endtask

  // Serial frame: start, 8 data LSB first, optional parity, one stop, optional break.
  task automatic send(input bit sel, input logic [7:0] d, input bit use_par, input logic par_b,
                      input logic stop_v, input int div, input int brk_bits);
    drive(sel, 1'b0);
    wait_cyc(div);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      wait_cyc(div);
    end
    if (use_par) begin
      drive(sel, par_b);
      wait_cyc(div);
    end
    drive(sel, stop_v);
    wait_cyc(div);
    if (brk_bits > 0) begin
      drive(sel, 1'b0);
      wait_cyc(div * brk_bits);
    end
    drive(sel, 1'b1);
  endtask

  task automatic send_e(input logic [7:0] d);
    send(1'b1, d, 1'b1, epar(d), 1'b1, 16, 0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Pop every word the DUT holds and compare it with the scoreboard.
  task automatic drain(input bit sel, input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while ((sel ? rd_valid_e : rd_valid_n) && n < 16) begin
      if ((sel ? q_e.size() : q_n.size()) == 0) begin
        checks++;
        failures++;
        $display("FAIL %s extra word: got %0h expected none", tag, sel ? rd_data_e : rd_data_n);
      end else begin
        e = sel ? q_e.pop_front() : q_n.pop_front();
        chk($sformatf("%s word", tag), sel ? rd_data_e : rd_data_n, e);
      end
      if (sel) rd_en_e = 1'b1; else rd_en_n = 1'b1;
      @(negedge clk);
      rd_en_e = 1'b0;
      rd_en_n = 1'b0;
      n++;
    end
    chk($sformatf("%s words left", tag), sel ? q_e.size() : q_n.size(), 0);
  endtask

  initial begin
    resetn = 1'b0; err_clr = 1'b0; rx_n = 1'b1; rx_e = 1'b1;
    rd_en_n = 1'b0; rd_en_e = 1'b0; cfg_div_n = 16'd106; cfg_div_e = 16'd16;
    tbl[0] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;

    wait_cyc(3);
    chk("reset rd_valid_e", rd_valid_e, 0);
    chk("reset level_e", level_e, 0);
    chk("reset rd_data_e", rd_data_e, 0);
    chk("reset flags_e", {ferr_e, perr_e, ovr_e}, 0);
    chk("reset level_n", level_n, 0);
    chk("reset flags_n", {ferr_n, perr_n, ovr_n}, 0);
    resetn = 1'b1;
    wait_cyc(2);

    // Read while empty is ignored.
    rd_en_e = 1'b1;
    @(negedge clk);
    rd_en_e = 1'b0;
    chk("empty read level", level_e, 0);
    chk("empty read valid", rd_valid_e, 0);
    chk("empty read flags", {ferr_e, perr_e, ovr_e}, 0);

    // Latency: rd_valid first seen 3 + div/2 + 10*div edges after rx falls (8E1, div 16).
    lat = 0;
    fork
      send_e(8'hC3);
      begin
        while (!rd_valid_e && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    q_e.push_back(8'hC3);
    chk("latency", lat, 171);
    drain(1'b1, "latency");

    // Table of single 8E1 frames.
    for (int i = 0; i < 7; i++) begin
      send(1'b1, tbl[i].data, 1'b1, epar(tbl[i].data) ^ tbl[i].flip, tbl[i].stop_v, 16, 0);
      if (tbl[i].exp_push) q_e.push_back(tbl[i].data);
      wait_cyc(4);
      chk($sformatf("tbl%0d parity_err", i), perr_e, tbl[i].exp_perr);
      chk($sformatf("tbl%0d frame_err", i), ferr_e, tbl[i].exp_ferr);
      chk($sformatf("tbl%0d level", i), level_e, tbl[i].exp_push ? 1 : 0);
      drain(1'b1, $sformatf("tbl%0d", i));
      pulse_clr();
    end

    // cfg_div below 4 runs at 4 clocks per bit.
    cfg_div_e = 16'd2;
    send(1'b1, 8'h96, 1'b1, epar(8'h96), 1'b1, 4, 0);
    q_e.push_back(8'h96);
    wait_cyc(4);
    chk("div min level", level_e, 1);
    chk("div min flags", {ferr_e, perr_e, ovr_e}, 0);
    drain(1'b1, "div min");
    cfg_div_e = 16'd16;

    // Break: low stop then rx low for 20 bits gives one frame error only.
    fork
      send(1'b1, 8'h5A, 1'b1, epar(8'h5A), 1'b0, 16, 20);
      begin
        wait_cyc(11 * 16 + 32);
        chk("break frame_err", ferr_e, 1);
        chk("break level", level_e, 0);
        pulse_clr();
        wait_cyc(10 * 16);
        chk("break no repeat", ferr_e, 0);
      end
    join
    wait_cyc(4);
    send_e(8'h3C);
    q_e.push_back(8'h3C);
    wait_cyc(4);
    chk("after break level", level_e, 1);
    chk("after break flags", {ferr_e, perr_e, ovr_e}, 0);
    drain(1'b1, "after break");

    // Overrun: five words into a depth-4 FIFO with no reads.
    for (int i = 0; i < 5; i++) begin
      send_e(words[i]);
      if (i < 4) q_e.push_back(words[i]);
    end
    wait_cyc(4);
    chk("overrun level", level_e, 4);
    chk("overrun flag", ovr_e, 1);
    drain(1'b1, "overrun");
    pulse_clr();
    chk("overrun cleared", ovr_e, 0);

    // Full FIFO with a read on the push edge: pop and push together.
    for (int i = 0; i < 4; i++) begin
      send_e(words[i]);
      q_e.push_back(words[i]);
    end
    fork
      send_e(words[4]);
      begin
        wait_cyc(170);
        chk("full rw head", rd_data_e, q_e.pop_front());
        rd_en_e = 1'b1;
        @(negedge clk);
        rd_en_e = 1'b0;
        chk("full rw level", level_e, 4);
      end
    join
    q_e.push_back(words[4]);
    wait_cyc(4);
    chk("full rw overrun", ovr_e, 0);
    chk("full rw level end", level_e, 4);
    drain(1'b1, "full rw");

    // 8N1 back-to-back frames at div 106.
    send(1'b0, 8'h41, 1'b0, 1'b0, 1'b1, 106, 0);
    send(1'b0, 8'h0A, 1'b0, 1'b0, 1'b1, 106, 0);
    q_n.push_back(8'h41);
    q_n.push_back(8'h0A);
    wait_cyc(4);
    chk("8n1 level", level_n, 2);
    chk("8n1 flags", {ferr_n, perr_n, ovr_n}, 0);
    drain(1'b0, "8n1");

    // 0.3-bit glitch is a false start.
    rx_e = 1'b0;
    wait_cyc(5);
    rx_e = 1'b1;
    wait_cyc(40);
    chk("glitch level", level_e, 0);
    chk("glitch flags", {ferr_e, perr_e, ovr_e}, 0);
    send_e(8'hE7);
    q_e.push_back(8'hE7);
    wait_cyc(4);
    chk("post glitch level", level_e, 1);
    drain(1'b1, "post glitch");

    // Reset mid-DATA with a stored word and a sticky flag.
    send(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 16, 0);
    send_e(8'h55);
    wait_cyc(4);
    chk("pre reset level", level_e, 1);
    chk("pre reset parity_err", perr_e, 1);
    fork
      send_e(8'h99);
      begin
        wait_cyc(60);
        resetn = 1'b0;
        #1;
        chk("mid reset rd_valid", rd_valid_e, 0);
        chk("mid reset level", level_e, 0);
        chk("mid reset rd_data", rd_data_e, 0);
        chk("mid reset flags", {ferr_e, perr_e, ovr_e}, 0);
      end
    join
    q_e.delete();
    wait_cyc(2);
    resetn = 1'b1;
    wait_cyc(2);
    send_e(8'h6C);
    q_e.push_back(8'h6C);
    wait_cyc(4);
    chk("post reset level", level_e, 1);
    chk("post reset flags", {ferr_e, perr_e, ovr_e}, 0);
    drain(1'b1, "post reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
